// File: rtl/stream_arbiter_if.sv
// Stream arbiter bus: N requester streams in, one granted stream out.
// slave  : the arbiter side (takes requests, drives grants and ready).
// master : the environment side (drives requests and downstream ready).
interface stream_arbiter_if #(
  parameter int  N          = 2,
  parameter int  DATA_WIDTH = 1,
  parameter type TYPE       = logic [DATA_WIDTH-1:0]
);
  localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  TYPE                  in_data [N];
  logic [N-1:0]         in_last;
  logic                 out_valid;
  logic                 out_ready;
  TYPE                  out_data;
  logic                 out_last;
  logic [SEL_WIDTH-1:0] out_sel;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/stream_arbiter.sv
// Packet-fair round-robin stream arbiter with a zero-latency datapath.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | grant searched combinationally from ptr over in_valid
// HOLD   | grant offered but not yet accepted downstream; grant frozen
// LOCKED | packet in progress on the registered grant; others ignored
//
// ptr only advances when a last beat transfers, so a requester keeps
// the output for a whole packet and fairness is counted in packets.
module stream_arbiter #(
  parameter int  N          = 2,
  parameter int  DATA_WIDTH = 1,
  parameter type TYPE       = logic [DATA_WIDTH-1:0]
) (
  input  logic            clk,
  input  logic            rstn,
  stream_arbiter_if.slave bus
);
  localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1;
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N - 1);

  if (N < 1) begin : g_bad_n
    $fatal(1, "stream_arbiter: N must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0] rr_gnt;
  logic [SEL_WIDTH-1:0] grant;
  logic                 found;
  logic                 valid_w;
  logic                 last_w;
  logic                 xfer;
  TYPE                  data_mux;

  // Round-robin search: first valid at or above ptr, then wrap below ptr.
  // With nothing valid the grant rests on ptr so out_sel shows the pointer.
  always_comb begin
    rr_gnt = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && (i >= int'(ptr_q)) && bus.in_valid[i]) begin
        rr_gnt = SEL_WIDTH'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && (i < int'(ptr_q)) && bus.in_valid[i]) begin
        rr_gnt = SEL_WIDTH'(i);
        found  = 1'b1;
      end
    end
  end

  assign grant    = (state_q == IDLE) ? rr_gnt : gnt_q;
  // Reset gating keeps the handshake quiet while rstn is low.
  assign valid_w  = rstn && bus.in_valid[grant];
  assign last_w   = bus.in_last[grant];
  assign data_mux = bus.in_data[grant];
  assign xfer     = valid_w && bus.out_ready;

  assign bus.out_valid = valid_w;
  assign bus.out_last  = last_w;
  assign bus.out_data  = data_mux;
  assign bus.out_sel   = grant;

  // Only the granted requester sees ready, and only when it is offering a beat.
  always_comb begin
    bus.in_ready = '0;
    if (xfer) begin
      bus.in_ready[grant] = 1'b1;
    end
  end

  // Next-state: a last beat always releases the grant and advances ptr.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    if (xfer && last_w) begin
      state_d = IDLE;
      ptr_d   = (grant == LAST_IDX) ? '0 : grant + 1'b1;
    end else if (xfer) begin
      state_d = LOCKED;
      gnt_d   = grant;
    end else if (valid_w && (state_q == IDLE)) begin
      state_d = HOLD;
      gnt_d   = grant;
    end
  end

  // State, pointer and held grant registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench: an N=4 and an N=2 arbiter, directed scenarios with
// literal expectations, then randomized traffic against a packet-level model.
module tb_stream_arbiter;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  stream_arbiter_if #(.N(4), .DATA_WIDTH(8)) a4 ();
  stream_arbiter_if #(.N(2), .DATA_WIDTH(8)) a2 ();

  stream_arbiter #(.N(4), .DATA_WIDTH(8)) dut4 (.clk(clk), .rstn(rstn), .bus(a4));
  stream_arbiter #(.N(2), .DATA_WIDTH(8)) dut2 (.clk(clk), .rstn(rstn), .bus(a2));

  int n_chk  = 0;
  int n_pass = 0;

  // Model: per DUT, next packet pointer and current owner (-1 = none).
  int mptr [2] = '{0, 0};
  int mown [2] = '{-1, -1};

  int sel33 [4] = '{1, 3, 1, 3};
  int ptr33 [4] = '{2, 0, 2, 0};
  int sel38 [5] = '{0, 1, 2, 3, 0};

  logic [3:0] fired4;
  logic [1:0] fired2;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Owner keeps the output until its last beat moves; otherwise first valid
  // requester at or after ptr, resting on ptr when nobody asks.
  task automatic model_step(input int u, input int n, input logic rst_n,
                            input logic [3:0] v, input logic [3:0] l,
                            input logic [31:0] dv, input logic ordy,
                            input logic ov, input logic [3:0] ir,
                            input logic [7:0] od, input logic ol, input int osel);
    int   g;
    logic ev;
    logic [3:0] eir;
    if (!rst_n) begin
      mptr[u] = 0;
      mown[u] = -1;
      chk($sformatf("m%0d_rst_ov", u), ov, 0);
      chk($sformatf("m%0d_rst_ir", u), ir, 0);
    end else begin
      if (mown[u] >= 0) g = mown[u];
      else begin
        g = mptr[u];
        for (int k = n - 1; k >= 0; k--)
          if (v[(mptr[u] + k) % n]) g = (mptr[u] + k) % n;
      end
      ev  = v[g];
      eir = (ev && ordy) ? (4'b0001 << g) : 4'b0000;
      chk($sformatf("m%0d_ov", u), ov, ev);
      chk($sformatf("m%0d_ir", u), ir, eir);
      chk($sformatf("m%0d_sel", u), osel, g);
      if (ev) begin
        chk($sformatf("m%0d_data", u), od, dv[g*8 +: 8]);
        chk($sformatf("m%0d_last", u), ol, l[g]);
      end
      if (ev && ordy) begin
        if (l[g]) begin
          mptr[u] = (g + 1) % n;
          mown[u] = -1;
        end else mown[u] = g;
      end else if (ev) mown[u] = g;
    end
  endtask

  // Compare process: outputs are stable mid-cycle, so check on the falling edge.
  always @(negedge clk) begin
    model_step(0, 4, rstn, a4.in_valid, a4.in_last,
               {a4.in_data[3], a4.in_data[2], a4.in_data[1], a4.in_data[0]},
               a4.out_ready, a4.out_valid, a4.in_ready, a4.out_data, a4.out_last,
               int'(a4.out_sel));
    model_step(1, 2, rstn, {2'b00, a2.in_valid}, {2'b00, a2.in_last},
               {16'h0000, a2.in_data[1], a2.in_data[0]},
               a2.out_ready, a2.out_valid, {2'b00, a2.in_ready}, a2.out_data,
               a2.out_last, int'(a2.out_sel));
    fired4 = a4.in_valid & a4.in_ready;
    fired2 = a2.in_valid & a2.in_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input logic [3:0] v, input logic [3:0] l, input logic r);
    a4.in_valid  = v;
    a4.in_last   = l;
    a4.out_ready = r;
    for (int i = 0; i < 4; i++) a4.in_data[i] = 8'($urandom);
  endtask

  task automatic set2(input logic [1:0] v, input logic [1:0] l, input logic r);
    a2.in_valid  = v;
    a2.in_last   = l;
    a2.out_ready = r;
    for (int i = 0; i < 2; i++) a2.in_data[i] = 8'($urandom);
  endtask

  initial begin
    rstn = 1'b0;
    set4(4'hF, 4'hF, 1'b1);
    set2(2'b11, 2'b11, 1'b1);
    @(negedge clk);
    #1;
    chk("rst_ov4", a4.out_valid, 0);
    chk("rst_ir4", a4.in_ready, 0);
    chk("rst_ov2", a2.out_valid, 0);
    tick();
    rstn = 1'b1;
    set4(4'h0, 4'h0, 1'b1);
    set2(2'b00, 2'b00, 1'b1);
    tick();

    // Alternating requesters 1 and 3 with single-beat packets.
    for (int k = 0; k < 4; k++) begin
      set4(4'b1010, 4'hF, 1'b1);
      @(negedge clk);
      #1;
      chk("r33_sel", a4.out_sel, sel33[k]);
      chk("r33_ptr", mptr[0], ptr33[k]);
      tick();
    end
    set4(4'h0, 4'h0, 1'b1);
    tick();

    // All requesting, single beats: one grant per cycle in rotation.
    for (int k = 0; k < 5; k++) begin
      set4(4'hF, 4'hF, 1'b1);
      @(negedge clk);
      #1;
      chk("r38_sel", a4.out_sel, sel38[k]);
      chk("r38_ov", a4.out_valid, 1);
      tick();
    end
    set4(4'h0, 4'h0, 1'b1);
    tick();

    // 3-beat packet on req0 while req1 waits.
    for (int k = 0; k < 4; k++) begin
      set2({1'b1, k < 3}, {1'b1, k == 2}, 1'b1);
      @(negedge clk);
      #1;
      chk("r34_sel", a2.out_sel, (k < 3) ? 0 : 1);
      chk("r34_ir1", a2.in_ready[1], k == 3);
      tick();
    end
    set2(2'b00, 2'b00, 1'b1);
    tick();

    // Stalled offer on req1 holds its grant when req0 joins.
    for (int k = 0; k < 5; k++) begin
      set2((k < 3) ? 2'b10 : 2'b11, 2'b11, k == 4);
      @(negedge clk);
      #1;
      chk("r35_sel", a2.out_sel, 1);
      chk("r35_ir", a2.in_ready, (k == 4) ? 2 : 0);
      tick();
    end
    set2(2'b00, 2'b00, 1'b1);
    tick();

    // Gap inside req0's packet: req1 must wait for req0's last beat.
    set2(2'b01, 2'b00, 1'b1);
    @(negedge clk);
    #1;
    chk("r36_first", a2.out_sel, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      set2(2'b10, 2'b11, 1'b1);
      @(negedge clk);
      #1;
      chk("r36_gap_ov", a2.out_valid, 0);
      chk("r36_gap_sel", a2.out_sel, 0);
      chk("r36_gap_ir", a2.in_ready, 0);
      tick();
    end
    set2(2'b11, 2'b11, 1'b1);
    @(negedge clk);
    #1;
    chk("r36_last_ir", a2.in_ready, 1);
    tick();
    set2(2'b10, 2'b11, 1'b1);
    @(negedge clk);
    #1;
    chk("r36_next_sel", a2.out_sel, 1);
    tick();
    set2(2'b00, 2'b00, 1'b1);

    // Reset in the middle of a locked packet on req2.
    set4(4'b0100, 4'h0, 1'b1);
    @(negedge clk);
    #1;
    chk("r37_start", a4.out_sel, 2);
    tick();
    set4(4'hF, 4'h0, 1'b1);
    @(negedge clk);
    #1;
    chk("r37_lock_sel", a4.out_sel, 2);
    chk("r37_lock_ir", a4.in_ready, 4);
    tick();
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("r37_rst_ov", a4.out_valid, 0);
      chk("r37_rst_ir", a4.in_ready, 0);
      tick();
    end
    rstn = 1'b1;
    set4(4'hF, 4'hF, 1'b1);
    @(negedge clk);
    #1;
    chk("r37_after_sel", a4.out_sel, 0);
    tick();
    @(negedge clk);
    #1;
    chk("r37_after_sel2", a4.out_sel, 1);
    tick();
    set4(4'h0, 4'h0, 1'b1);
    set2(2'b00, 2'b00, 1'b1);
    tick();

    // Random traffic; each requester holds its beat until it transfers.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) rstn = 1'b0;
      if (c == 1502) rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (!a4.in_valid[i] || fired4[i]) begin
          a4.in_valid[i] = ($urandom_range(0, 3) != 0);
          a4.in_last[i]  = ($urandom_range(0, 2) == 0);
          a4.in_data[i]  = 8'($urandom);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!a2.in_valid[i] || fired2[i]) begin
          a2.in_valid[i] = ($urandom_range(0, 3) != 0);
          a2.in_last[i]  = ($urandom_range(0, 2) == 0);
          a2.in_data[i]  = 8'($urandom);
        end
      end
      a4.out_ready = ($urandom_range(0, 3) != 0);
      a2.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
